// File: rtl/rom_download_ctrl.sv
// -----------------------------------------------------------------------------
// rom_download_ctrl
//   Steers the HPS ioctl ROM download stream into the three williams2 ROM
//   regions (program, sound, graphics). Each accepted byte produces a one-hot
//   write with a region-relative address. The HPS is stalled with ioctl_wait
//   until the target memory acknowledges. The core is held in reset while a
//   download runs and for HOLD_CYCLES cycles after it ends.
//
// Ports
//   clk_sys         in   1   system clock
//   reset_n         in   1   asynchronous active-low reset
//   ioctl_download  in   1   download in progress
//   ioctl_index     in   8   download file index
//   ioctl_wr        in   1   one-cycle byte strobe
//   ioctl_addr      in   17  byte address within the file
//   ioctl_dout      in   8   byte data
//   ioctl_wait      out  1   stall request back to hps_io
//   mem_we          out  3   one-hot write enable: [0] prog, [1] sound, [2] gfx
//   mem_addr        out  17  address relative to the selected region base
//   mem_data        out  8   write data
//   mem_ack         in   1   target accepted the write
//   core_reset      out  1   active-high reset to the core
//   rom_loaded      out  1   a complete ROM set has been loaded
//   drop_count      out  8   out-of-range bytes this download, saturating
// -----------------------------------------------------------------------------
module rom_download_ctrl #(
   parameter logic [7:0]  ROM_INDEX   = 8'd0,
   parameter logic [16:0] SND_BASE    = 17'h0C000,
   parameter logic [16:0] GFX_BASE    = 17'h10000,
   parameter logic [16:0] ROM_END     = 17'h1C000,
   parameter int          HOLD_CYCLES = 16
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [16:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic [2:0]  mem_we,
   output logic [16:0] mem_addr,
   output logic [7:0]  mem_data,
   input  logic        mem_ack,
   output logic        core_reset,
   output logic        rom_loaded,
   output logic [7:0]  drop_count
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
   // Loaded on the edge that enters HOLD; RUN is reached HOLD_CYCLES edges later.
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_HOLD,
      S_RUN
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] hold_cnt;

   logic        idx_match;
   logic        dl_match;
   logic        wr_match;
   logic [2:0]  dec_we;
   logic [16:0] dec_addr;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign idx_match = (ioctl_index == ROM_INDEX);
   assign dl_match  = ioctl_download && idx_match;
   assign wr_match  = ioctl_wr && idx_match;

   // Region decode; dec_we stays zero for addresses at or beyond ROM_END.
   // Each subtraction only happens once the address is known to be above the
   // base, so it cannot wrap.
   always_comb begin
      dec_we   = 3'b000;
      dec_addr = '0;
      if (ioctl_addr < SND_BASE) begin
         dec_we   = 3'b001;
         dec_addr = ioctl_addr;
      end else if (ioctl_addr < GFX_BASE) begin
         dec_we   = 3'b010;
         dec_addr = ioctl_addr - SND_BASE;
      end else if (ioctl_addr < ROM_END) begin
         dec_we   = 3'b100;
         dec_addr = ioctl_addr - GFX_BASE;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         ioctl_wait <= 1'b0;
         mem_we     <= 3'b000;
         mem_addr   <= '0;
         mem_data   <= '0;
         core_reset <= 1'b1;
         rom_loaded <= 1'b0;
         drop_count <= '0;
         hold_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE, S_RUN: begin
               if (dl_match) begin
                  state      <= S_LOAD;
                  core_reset <= 1'b1;
                  rom_loaded <= 1'b0;
                  drop_count <= '0;
               end
            end

            S_LOAD: begin
               if (wr_match) begin
                  if (dec_we != 3'b000) begin
                     state      <= S_WRITE;
                     mem_we     <= dec_we;
                     mem_addr   <= dec_addr;
                     mem_data   <= ioctl_dout;
                     ioctl_wait <= 1'b1;
                  end else begin
                     drop_count <= sat_inc(drop_count);
                     if (!dl_match) begin
                        state    <= S_HOLD;
                        hold_cnt <= HOLD_LOAD;
                     end
                  end
               end else if (!dl_match) begin
                  state    <= S_HOLD;
                  hold_cnt <= HOLD_LOAD;
               end
            end

            // Write outputs stay frozen until the target acknowledges. A
            // strobe arriving here is a protocol error and is ignored. The
            // download flag is sampled only at ack time, so a byte that
            // coincided with the falling download edge still completes.
            S_WRITE: begin
               if (mem_ack) begin
                  mem_we     <= 3'b000;
                  ioctl_wait <= 1'b0;
                  if (dl_match) begin
                     state <= S_LOAD;
                  end else begin
                     state    <= S_HOLD;
                     hold_cnt <= HOLD_LOAD;
                  end
               end
            end

            S_HOLD: begin
               if (dl_match) begin
                  state      <= S_LOAD;
                  core_reset <= 1'b1;
                  rom_loaded <= 1'b0;
                  drop_count <= '0;
               end else if (hold_cnt == '0) begin
                  state      <= S_RUN;
                  core_reset <= 1'b0;
                  rom_loaded <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt - CNT_W'(1);
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
